// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch queue.
package ifetch_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ir;
  } fetch_entry_t;

  // Word address of a byte PC; callers keep the low IMEM_AW bits.
  function automatic logic [31:0] word_addr(input logic [31:0] byte_pc);
    return byte_pc >> 2;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetched {pc, ir} entries; clear empties it in one cycle.
module fetch_fifo
  import ifetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PW = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  input  logic         clear,
  output logic         full,
  output logic         empty,
  output logic [PW:0]  count,
  output fetch_entry_t head
);

  localparam logic [PW:0] FULL_CNT = {1'b1, {PW{1'b0}}};

  fetch_entry_t    mem [DEPTH];
  logic [PW-1:0]   rptr;
  logic [PW-1:0]   wptr;
  logic            do_push;
  logic            do_pop;

  assign do_push = push && !clear;
  assign do_pop  = pop && !clear && !empty;

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  assign head  = mem[rptr];

endmodule

// File: rtl/ifetch_queue.sv
// Fetch front end: issues sequential IMEM reads, buffers returns, serves decode
// through a valid/ready handshake and restarts cleanly on redirect.
module ifetch_queue
  import ifetch_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned IMEM_AW  = 14
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               REDIRECT,
  input  logic [31:0]        REDIRECT_PC,
  output logic               IMEM_RDEN,
  output logic [IMEM_AW-1:0] IMEM_ADDR,
  input  logic [31:0]        IMEM_DATA,
  output logic               OUT_VALID,
  input  logic               OUT_READY,
  output logic [31:0]        OUT_PC,
  output logic [31:0]        OUT_NEXTPC,
  output logic [31:0]        OUT_IR
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [31:0]   fetch_pc;
  logic [31:0]   inflight_pc;
  logic          inflight;
  logic          squash;
  logic          issue;
  logic          push;
  logic          pop;
  logic          full;
  logic          empty;
  logic [PW:0]   count;
  logic [31:0]   used;
  logic [31:0]   fetch_word;
  logic          unused_bits;
  fetch_entry_t  head;
  fetch_entry_t  ret_entry;

  // Credit counts in-flight reads but not same-cycle pops, so a return always has a slot.
  assign used      = 32'(count) + 32'(inflight);
  assign issue     = !RST && !REDIRECT && (used < DEPTH);
  assign IMEM_RDEN = issue;

  assign fetch_word  = word_addr(fetch_pc);
  assign IMEM_ADDR   = fetch_word[IMEM_AW-1:0];
  assign unused_bits = ^{fetch_word[31:IMEM_AW], REDIRECT_PC[1:0]};

  assign ret_entry = '{pc: inflight_pc, ir: IMEM_DATA};
  assign push      = inflight && !squash && !REDIRECT;
  assign pop       = OUT_VALID && OUT_READY && !REDIRECT;

  always_ff @(posedge CLK) begin
    if (RST) begin
      fetch_pc    <= RESET_PC;
      inflight_pc <= RESET_PC;
      inflight    <= 1'b0;
      squash      <= 1'b0;
    end else begin
      inflight <= issue;
      squash   <= REDIRECT && inflight;
      if (issue) begin
        inflight_pc <= fetch_pc;
        fetch_pc    <= fetch_pc + 32'd4;
      end
      if (REDIRECT) fetch_pc <= {REDIRECT_PC[31:2], 2'b00};
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (CLK),
    .rst       (RST),
    .push      (push),
    .push_data (ret_entry),
    .pop       (pop),
    .clear     (REDIRECT),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .head      (head)
  );

  always_ff @(posedge CLK) begin
    if (!RST) assert (!(push && full));
  end

  assign OUT_VALID  = !empty;
  assign OUT_PC     = empty ? fetch_pc : head.pc;
  assign OUT_NEXTPC = OUT_PC + 32'd4;
  assign OUT_IR     = empty ? NOP_INSTR : head.ir;

endmodule
